// File: rtl/pipe_arb_pkg.sv
// -----------------------------------------------------------------------------
// pipe_arb_pkg
// Shared types and elaboration-time helpers for the pipelined round-robin
// arbiter: the FSM state encoding, a ceiling-log2 helper and the derivation
// of the source-index width.
// -----------------------------------------------------------------------------
package pipe_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Source index width: at least one bit even for degenerate N.
  function automatic int src_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans requesters starting just after the
// last-served index (ptr+1, ptr+2, ... mod N) and returns the first one that
// is requesting.
//   req   : request vector, one bit per requester
//   ptr   : index of the requester served most recently
//   valid : at least one request present
//   idx   : chosen requester (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick
  import pipe_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SRC_W = src_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic             valid,
  output logic [SRC_W-1:0] idx
);

  int cand;

  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    valid = |req;
    idx   = '0;
    cand  = 0;
    // Walk the scan order backwards so the earliest candidate is the last
    // one written and therefore wins.
    for (int i = N; i >= 1; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) begin
        idx = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_rr_arbiter
// Round-robin arbiter merging N have/want requester streams into one
// have/want stream. A grant is held for a whole packet, ending on the
// requester's last flag or after MAX_BURST beats, whichever comes first.
// One IDLE cycle separates consecutive grants. The merged beat sits in a
// registered output slot; the accept path back to the requesters
// (o_want) is combinational from i_want.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous, active-high reset
//   i_in     : requester data, requester k at [k*WIDTH +: WIDTH]
//   i_have   : requester k presents a beat
//   i_last   : requester k's beat ends its packet
//   o_want   : arbiter accepts requester k's beat this cycle
//   o_out    : merged beat
//   o_last   : merged beat ends its grant (packet end or burst limit)
//   o_src    : requester index of the merged beat
//   o_have   : merged beat valid
//   i_want   : downstream accepts the merged beat
// -----------------------------------------------------------------------------
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N*WIDTH-1:0]      i_in,
  input  logic [N-1:0]            i_have,
  input  logic [N-1:0]            i_last,
  output logic [N-1:0]            o_want,
  output logic [WIDTH-1:0]        o_out,
  output logic                    o_last,
  output logic [src_width(N)-1:0] o_src,
  output logic                    o_have,
  input  logic                    i_want
);

  localparam int SRC_W = src_width(N);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST);

  arb_state_t       state_q;
  logic [SRC_W-1:0] gnt_q;
  logic [SRC_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             slot_ready;
  logic             granted;
  logic             take;
  logic             end_of_grant;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] gnt_data;
  logic             pick_valid;
  logic [SRC_W-1:0] pick_idx;

  // The slot can take a new beat when it is empty or being drained now.
  assign slot_ready   = !o_have || i_want;
  assign granted      = (state_q == GRANT);
  assign take         = granted && slot_ready && i_have[gnt_q];
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign end_of_grant = i_last[gnt_q] || (cnt_inc == BURST_END);
  assign gnt_data     = i_in[gnt_q*WIDTH +: WIDTH];

  // Only the granted requester ever sees want; it does not depend on that
  // requester's own have, so a requester that pauses keeps its grant.
  always_comb begin
    o_want = '0;
    if (granted && slot_ready) begin
      o_want[gnt_q] = 1'b1;
    end
  end

  rr_pick #(
    .N     (N),
    .SRC_W (SRC_W)
  ) u_pick (
    .req   (i_have),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // ptr starts at N-1 so requester 0 is scanned first after reset.
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= SRC_W'(N - 1);
      cnt_q   <= '0;
      o_have  <= 1'b0;
      o_out   <= '0;
      o_last  <= 1'b0;
      o_src   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // With no transfer the grant simply holds; there is no timeout.
          if (take) begin
            cnt_q <= cnt_inc;
            if (end_of_grant) begin
              state_q <= IDLE;
              ptr_q   <= gnt_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Output slot: reload whenever it is free or draining, otherwise hold
      // the presented beat stable for the stalled consumer.
      if (slot_ready) begin
        o_have <= take;
        if (take) begin
          o_out  <= gnt_data;
          o_src  <= gnt_q;
          o_last <= end_of_grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipe_rr_arbiter
// Directed scoreboard bench for pipe_rr_arbiter (N=4, WIDTH=32, MAX_BURST=4).
// Requester queues feed the DUT; expected merged beats are pushed to a
// scoreboard when stimulus is issued and a monitor pops and compares each
// beat the DUT hands downstream.
// -----------------------------------------------------------------------------
module tb_pipe_rr_arbiter;
  import pipe_arb_pkg::*;

  localparam int WIDTH     = 32;
  localparam int N         = 4;
  localparam int MAX_BURST = 4;
  localparam int SRC_W     = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [WIDTH-1:0] data;
    logic             last;
  } out_t;

  logic               i_clk;
  logic               i_reset;
  logic [N*WIDTH-1:0] i_in;
  logic [N-1:0]       i_have;
  logic [N-1:0]       i_last;
  logic [N-1:0]       o_want;
  logic [WIDTH-1:0]   o_out;
  logic               o_last;
  logic [SRC_W-1:0]   o_src;
  logic               o_have;
  logic               i_want;

  beat_t      src_q [N][$];
  out_t       sb [$];
  int         xfer_cyc [$];
  logic [N-1:0] pause;
  int         cycle;
  int         n_checks;
  int         n_pass;

  pipe_rr_arbiter #(
    .WIDTH     (WIDTH),
    .N         (N),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_in    (i_in),
    .i_have  (i_have),
    .i_last  (i_last),
    .o_want  (o_want),
    .o_out   (o_out),
    .o_last  (o_last),
    .o_src   (o_src),
    .o_have  (o_have),
    .i_want  (i_want)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    cycle = 0;
    forever begin
      @(posedge i_clk);
      cycle = cycle + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        i_in[k*WIDTH +: WIDTH] = src_q[k][0].data;
        i_last[k]              = src_q[k][0].last;
        i_have[k]              = !pause[k];
      end else begin
        i_in[k*WIDTH +: WIDTH] = '0;
        i_last[k]              = 1'b0;
        i_have[k]              = 1'b0;
      end
    end
  endtask

  task automatic load(input int k, input logic [WIDTH-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[k].push_back(b);
  endtask

  task automatic expect_out(input logic [SRC_W-1:0] s, input logic [WIDTH-1:0] d, input logic l);
    out_t e;
    e.src  = s;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  function automatic bit busy();
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while ((sb.size() != 0 || busy()) && b < 200) begin
      cyc();
      b = b + 1;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    repeat (2) cyc();
  endtask

  // Requester model: a beat leaves its queue after an edge where it was
  // offered and wanted.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge i_clk);
      acc = i_have & o_want;
      @(posedge i_clk);
      #1;
      if (!i_reset) begin
        for (int k = 0; k < N; k++) begin
          if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
      end
      drive_inputs();
    end
  end

  // Monitor: compare every downstream transfer against the scoreboard.
  initial begin
    out_t e;
    forever begin
      @(negedge i_clk);
      if (!i_reset && o_have && i_want) begin
        xfer_cyc.push_back(cycle);
        if (sb.size() == 0) begin
          n_checks = n_checks + 1;
          $display("FAIL unexpected_beat: got src %0d data %0h, scoreboard empty", o_src, o_out);
        end else begin
          e = sb.pop_front();
          check("out_src", 64'(o_src), 64'(e.src));
          check("out_data", 64'(o_out), 64'(e.data));
          check("out_last", 64'(o_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    n_checks = 0;
    n_pass   = 0;
    i_reset  = 1'b1;
    i_want   = 1'b1;
    pause    = '0;
    drive_inputs();

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_have", 64'(o_have), 64'd0);
    check("rst_want", 64'(o_want), 64'd0);
    check("rst_out",  64'(o_out),  64'd0);
    check("rst_src",  64'(o_src),  64'd0);
    check("rst_last", 64'(o_last), 64'd0);
    cyc();
    i_reset = 1'b0;
    cyc();

    // T1: requesters 0 and 2, single-beat packets, alternate 0,2,0,2.
    expect_out(2'd0, 32'h10, 1'b1);
    expect_out(2'd2, 32'h20, 1'b1);
    expect_out(2'd0, 32'h11, 1'b1);
    expect_out(2'd2, 32'h21, 1'b1);
    load(0, 32'h10, 1'b1); load(0, 32'h11, 1'b1);
    load(2, 32'h20, 1'b1); load(2, 32'h21, 1'b1);
    drive_inputs();
    @(negedge i_clk); check("t1_have_t0", 64'(o_have), 64'd0);
    @(negedge i_clk); check("t1_have_t1", 64'(o_have), 64'd0);
    @(negedge i_clk); check("t1_have_t2", 64'(o_have), 64'd1);
    check("t1_first_src", 64'(o_src), 64'd0);
    drain("t1");

    // T2: 3-beat packet from 1, then 3 after one bubble.
    xfer_cyc.delete();
    expect_out(2'd1, 32'hA, 1'b0);
    expect_out(2'd1, 32'hB, 1'b0);
    expect_out(2'd1, 32'hC, 1'b1);
    expect_out(2'd3, 32'h3D, 1'b1);
    load(1, 32'hA, 1'b0); load(1, 32'hB, 1'b0); load(1, 32'hC, 1'b1);
    drive_inputs();
    cyc();
    load(3, 32'h3D, 1'b1);
    drive_inputs();
    drain("t2");
    check("t2_xfers", 64'(xfer_cyc.size()), 64'd4);
    if (xfer_cyc.size() == 4) begin
      check("t2_gap_ab",     64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
      check("t2_gap_bc",     64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
      check("t2_gap_bubble", 64'(xfer_cyc[3] - xfer_cyc[2]), 64'd2);
    end

    // T3: burst limit 4 splits a 6-beat packet from 0 around requester 2.
    expect_out(2'd0, 32'h40, 1'b0);
    expect_out(2'd0, 32'h41, 1'b0);
    expect_out(2'd0, 32'h42, 1'b0);
    expect_out(2'd0, 32'h43, 1'b1);
    expect_out(2'd2, 32'h50, 1'b1);
    expect_out(2'd0, 32'h44, 1'b0);
    expect_out(2'd0, 32'h45, 1'b1);
    for (int i = 0; i < 6; i++) load(0, 32'h40 + 32'(i), (i == 5));
    load(2, 32'h50, 1'b1);
    drive_inputs();
    drain("t3");

    // T4: downstream stall for 3 cycles mid-packet.
    expect_out(2'd1, 32'h60, 1'b0);
    expect_out(2'd1, 32'h61, 1'b0);
    expect_out(2'd1, 32'h62, 1'b0);
    expect_out(2'd1, 32'h63, 1'b1);
    for (int i = 0; i < 4; i++) load(1, 32'h60 + 32'(i), (i == 3));
    drive_inputs();
    w = 0;
    while (w < 20) begin
      @(negedge i_clk);
      if (o_have) break;
      w = w + 1;
    end
    check("t4_first_have", 64'(o_have), 64'd1);
    cyc();
    i_want = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("t4_stall_want", 64'(o_want), 64'd0);
      check("t4_stall_have", 64'(o_have), 64'd1);
      check("t4_stall_out",  64'(o_out),  64'h61);
      check("t4_stall_src",  64'(o_src),  64'd1);
      check("t4_stall_last", 64'(o_last), 64'd0);
    end
    cyc();
    i_want = 1'b1;
    drain("t4");

    // T5: granted requester 2 pauses for 2 cycles while 3 waits.
    expect_out(2'd2, 32'h70, 1'b0);
    expect_out(2'd2, 32'h71, 1'b0);
    expect_out(2'd2, 32'h72, 1'b1);
    expect_out(2'd3, 32'h80, 1'b1);
    load(2, 32'h70, 1'b0); load(2, 32'h71, 1'b0); load(2, 32'h72, 1'b1);
    drive_inputs();
    w = 0;
    while (src_q[2].size() != 2 && w < 20) begin
      cyc();
      w = w + 1;
    end
    check("t5_first_taken", 64'(src_q[2].size()), 64'd2);
    pause[2] = 1'b1;
    load(3, 32'h80, 1'b1);
    drive_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      check("t5_pause_want", 64'(o_want), 64'h4);
    end
    cyc();
    pause[2] = 1'b0;
    drive_inputs();
    drain("t5");

    // T6: reset during the second beat of a packet from 1.
    load(1, 32'h90, 1'b0); load(1, 32'h91, 1'b0); load(1, 32'h92, 1'b1);
    drive_inputs();
    w = 0;
    while (src_q[1].size() != 2 && w < 20) begin
      cyc();
      w = w + 1;
    end
    check("t6_first_taken", 64'(src_q[1].size()), 64'd2);
    i_reset = 1'b1;
    #1;
    check("t6_rst_have", 64'(o_have), 64'd0);
    check("t6_rst_want", 64'(o_want), 64'd0);
    check("t6_rst_out",  64'(o_out),  64'd0);
    check("t6_rst_src",  64'(o_src),  64'd0);
    check("t6_rst_last", 64'(o_last), 64'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    drive_inputs();
    cyc();
    cyc();
    i_reset = 1'b0;
    cyc();
    expect_out(2'd0, 32'hB0, 1'b1);
    expect_out(2'd1, 32'hB1, 1'b1);
    expect_out(2'd3, 32'hB3, 1'b1);
    load(3, 32'hB3, 1'b1);
    load(1, 32'hB1, 1'b1);
    load(0, 32'hB0, 1'b1);
    drive_inputs();
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_rr_arbiter.md
# pipe_rr_arbiter

Round-robin arbiter that shares one have/want pipeline stream between N requesting have/want streams. It sits in front of a shared pipeline stage and grants one requester at a time, holding the grant for a whole packet (up to a burst limit). The merged beat, its last flag and its source index are presented through a registered output slot.

## Interface
- WIDTH, 32: data bits per beat.
- N, 4: number of requesters (≥2).
- MAX_BURST, 16: maximum beats per grant (≥1).
- SRC_W, max(1,clog2(N)): source index width (derived, not overridden).
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_in  in  N*WIDTH  requester data, requester k at bits [k*WIDTH +: WIDTH].
- i_have  in  N  requester k has a beat.
- i_last  in  N  requester k's beat is the last of its packet.
- o_want  out  N  arbiter accepts requester k's beat this cycle.
- o_out  out  WIDTH  merged beat.
- o_last  out  1  merged beat is last of its grant.
- o_src  out  SRC_W  requester index of the merged beat.
- o_have  out  1  merged beat valid.
- i_want  in  1  downstream accepts the merged beat.

## Operation
- Input transfer on requester k: i_have[k] && o_want[k]. Output transfer: o_have && i_want.
- FSM states IDLE, GRANT; registers gnt (SRC_W), ptr (SRC_W), cnt (clog2(MAX_BURST+1)).
- IDLE: if any i_have, pick first k with i_have[k] scanning ptr+1, ptr+2, … mod N; at next edge gnt←k, cnt←0, state←GRANT. No requests: stay IDLE.
- GRANT: o_want[gnt] = (!o_have || i_want); all other o_want bits 0. In IDLE all o_want are 0.
- On an input transfer: cnt←cnt+1; if i_last[gnt] or cnt+1==MAX_BURST, state←IDLE, ptr←gnt.
- o_last is set for the beat ending the grant, whether by i_last or by the burst limit.
- No input transfer in GRANT, including when the requester drops i_have: hold the grant with no timeout.
- Output slot loads when (!o_have || i_want): o_have←input transfer; on transfer o_out←i_in[gnt], o_src←gnt, o_last←end-of-grant flag. Otherwise the slot holds.
- MAX_BURST=1: every grant is one beat.
- Reset values: state IDLE, ptr N-1 (requester 0 has first priority), gnt 0, cnt 0, o_have 0, o_out 0, o_last 0, o_src 0, o_want all 0.
- Reset mid-packet discards the partial packet and the output slot.

## Timing
- Request seen in IDLE at cycle t: grant registered at edge t+1; beat accepted in cycle t+1; o_have high in cycle t+2.
- Within a grant: one beat per cycle while i_want is held high.
- One IDLE bubble cycle between consecutive grants.
- o_want depends combinationally on i_want (same-cycle path, no skid buffer). o_have, o_out, o_last, o_src are registered.
- Downstream stall (o_have && !i_want): o_want drops the same cycle; the held beat is stable until accepted.

## Structure
- Package pipe_arb_pkg holds:
  - state enum (IDLE, GRANT);
  - clog2 helper function;
  - SRC_W derivation constant function.
- Sub-module rr_pick: combinational round-robin picker (inputs req[N] and ptr, outputs valid and idx). It is instantiated once for the IDLE decision.

## Test plan
- After reset, i_have=4'b0101 with single-beat packets and i_want=1: o_src sequence 0,2,0,2; o_have first high 2 cycles after the request.
- Requester 1 sends a 3-beat packet (0xA,0xB,0xC, last on 0xC) while requester 3 requests: out 0xA,0xB,0xC from src 1 back-to-back, o_last only on 0xC, then src 3 after one bubble cycle.
- MAX_BURST=4, requester 0 sends 6 beats without i_last while requester 2 waits: 4 beats from src 0 with o_last on the 4th, then src 2, then the remaining 2 beats of src 0.
- i_want=0 for 3 cycles mid-packet: o_out, o_src and o_last stay stable; o_want is 0; no beats are lost or duplicated; the stream resumes in order.
- Granted requester drops i_have for 2 cycles mid-packet: the grant holds and no other source appears; the packet completes after i_have returns.
- Assert i_reset during the 2nd beat of a packet: all outputs go to their reset values immediately; the next grant goes to the lowest-index requester.
